// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mdu_pkg;

  localparam int MDU_LATENCY = 33;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mdu_state_t;

  function automatic logic a_is_signed(mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(mdu_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - operand magnitudes on entry, sign restore and special-case overrides on exit
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mdu_op_t           fun,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  input  mdu_op_t           op_q,
  input  logic [XLEN-1:0]   a_q,
  input  logic [XLEN-1:0]   b_q,
  input  logic [XLEN-1:0]   acc_hi,
  input  logic [XLEN-1:0]   acc_lo,
  output logic [XLEN-1:0]   fixed
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              sa;
  logic              sb;
  logic              ovf;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // -MIN_NEG wraps to MIN_NEG, which read unsigned is exactly 2^(XLEN-1)
  assign mag_a = (a_is_signed(fun) && src_a[XLEN-1]) ? -src_a : src_a;
  assign mag_b = (b_is_signed(fun) && src_b[XLEN-1]) ? -src_b : src_b;

  always_comb begin
    sa   = a_is_signed(op_q) && a_q[XLEN-1];
    sb   = b_is_signed(op_q) && b_q[XLEN-1];
    ovf  = (a_q == MIN_NEG) && (b_q == '1);
    prod = {acc_hi, acc_lo};
    if (sa ^ sb) prod = -prod;
    quo  = (sa ^ sb) ? -acc_lo : acc_lo;
    rem  = sa ? -acc_hi : acc_hi;
    case (op_q)
      OP_MUL:                        fixed = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fixed = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (b_q == '0)                    fixed = '1;
        else if (op_q == OP_DIV && ovf)   fixed = MIN_NEG;
        else                              fixed = quo;
      end
      default: begin
        if (b_q == '0)                    fixed = a_q;
        else if (op_q == OP_REM && ovf)   fixed = '0;
        else                              fixed = rem;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - fixed-latency radix-2 RV32M multiply/divide unit
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CYCLES = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      fun,
  input  logic [XLEN-1:0] mux_srcA,
  input  logic [XLEN-1:0] mux_srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            CW   = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  mdu_state_t      state;
  mdu_op_t         op_q;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] opd;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] hi_nxt;
  logic [XLEN-1:0] lo_nxt;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] fixed;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .fun    (mdu_op_t'(fun)),
    .src_a  (mux_srcA),
    .src_b  (mux_srcB),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .op_q   (op_q),
    .a_q    (a_q),
    .b_q    (b_q),
    .acc_hi (hi_nxt),
    .acc_lo (lo_nxt),
    .fixed  (fixed)
  );

  // Multiply: acc_lo holds the multiplier, consumed LSB first as the product shifts in.
  // Divide: acc_lo holds the dividend, replaced by quotient bits; acc_hi is the partial remainder.
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    hi_nxt  = acc_hi;
    lo_nxt  = acc_lo;
    if (op_q[2]) begin
      shifted = {acc_hi, acc_lo[XLEN-1]};
      diff    = shifted - {1'b0, opd};
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      sum              = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
      {hi_nxt, lo_nxt} = {sum, acc_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      op_q   <= OP_MUL;
      count  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opd    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q   <= mdu_op_t'(fun);
            a_q    <= mux_srcA;
            b_q    <= mux_srcB;
            opd    <= fun[2] ? mag_b : mag_a;
            acc_lo <= fun[2] ? mag_a : mag_b;
            acc_hi <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          count  <= count + 1'b1;
          if (count == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fixed;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - randomized self-checking bench for mdu_iterative against an arithmetic model
module tb_mdu_iterative;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [2:0]  fun;
  logic [31:0] mux_srcA;
  logic [31:0] mux_srcB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests;
  int n_fail;

  mdu_iterative #(.XLEN(32), .CYCLES(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .fun      (fun),
    .mux_srcA (mux_srcA),
    .mux_srcB (mux_srcB),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'(b);
    logic [63:0] ua = {32'b0, a};
    logic [63:0] p;
    int          ia = a;
    int          ib = b;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;         return p[63:32]; end
      3'd2: begin p = sa * ub;         return p[63:32]; end
      3'd3: begin p = ua * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called #1 after an edge with the DUT in IDLE or DONE; returns #1 into the first busy cycle.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    fun      = op;
    mux_srcA = a;
    mux_srcB = b;
    start    = 1'b1;
    @(posedge CLK); #1;
    start    = 1'b0;
  endtask

  // Walks the 32 busy cycles, optionally pulsing start in busy cycle ign_cycle, and checks the done cycle.
  task automatic wait_result(input string tag, input logic [31:0] exp, input int ign_cycle);
    int bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (i == ign_cycle) begin
        start    = 1'b1;
        fun      = ~fun;
        mux_srcA = $urandom;
        mux_srcB = $urandom;
      end else begin
        start    = 1'b0;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    check({tag, "_busy_window"}, bad, 0);
    check({tag, "_done"}, {31'b0, done}, 1);
    check({tag, "_busy_low"}, {31'b0, busy}, 0);
    check(tag, result, exp);
  endtask

  task automatic check_tail(input string tag, input logic [31:0] exp);
    @(posedge CLK); #1;
    check({tag, "_done_one_cycle"}, {31'b0, done}, 0);
    check({tag, "_held"}, result, exp);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp = ref_mdu(op, a, b);
    start_op(op, a, b);
    wait_result(tag, exp, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          sel;
    int          spurious;

    n_tests  = 0;
    n_fail   = 0;
    RST      = 1'b1;
    start    = 1'b0;
    fun      = 3'd0;
    mux_srcA = '0;
    mux_srcB = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", result, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    check("model_mul", ref_mdu(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check_tail("mul_neg", 32'hFFFF_FFEB);
    run("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check("mulh_min_const", result, 32'h4000_0000);
    run("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000);
    check("mulhu_min_const", result, 32'h4000_0000);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    check("mulhsu_const", result, 32'hFFFF_FFFF);
    run("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_const", result, 32'hFFFF_FFFD);
    run("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_neg_const", result, 32'hFFFF_FFFF);
    run("divu_big", 3'd5, 32'hFFFF_FFF9, 32'd2);
    check("divu_big_const", result, 32'h7FFF_FFFC);
    run("divu_zero", 3'd5, 32'd100, 32'd0);
    check("divu_zero_const", result, 32'hFFFF_FFFF);
    run("rem_zero", 3'd6, 32'd100, 32'd0);
    check("rem_zero_const", result, 32'd100);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", result, 32'h8000_0000);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf_const", result, 32'h0);
    run("div_zero_neg", 3'd4, 32'hFFFF_FF00, 32'd0);
    run("remu_zero", 3'd7, 32'hDEAD_BEEF, 32'd0);

    start_op(3'd0, 32'd1234, 32'd5678);
    wait_result("ignore_in_calc", 32'd7006652, 5);
    start_op(3'd5, 32'd1000, 32'd7);
    wait_result("back_to_back", 32'd142, 0);
    check_tail("back_to_back", 32'd142);

    start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("rst_async_busy", {31'b0, busy}, 0);
    check("rst_async_done", {31'b0, done}, 0);
    check("rst_async_result", result, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
      @(posedge CLK); #1;
    end
    check("rst_no_done", spurious, 0);
    check("rst_result_zero", result, 0);
    run("after_rst", 3'd2, 32'h8765_4321, 32'hFFFF_0001);

    for (int n = 0; n < 48; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
      else if (sel == 3) b = b >> $urandom_range(1, 31);
      exp = ref_mdu(op, a, b);
      start_op(op, a, b);
      wait_result($sformatf("rand%0d_op%0d", n, op), exp, (n % 5 == 0) ? 3 : 0);
      if (n % 4 == 0) check_tail($sformatf("rand%0d", n), exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
